// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-requester ROM arbiter:
// FSM state encoding, default geometry and counter sizing.
package rom_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF  = 24;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    // Width of the WAIT counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: a lone request wins outright; a tie goes to
// requester 0 under fixed priority, else to the one not served last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_served,
    input  logic       fixed_pri,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (fixed_pri || last_served) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one ROM controller between a sound and a dma requester,
// with per-requester read data, completion pulse and timeout flag.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_load,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              req0_err,
    input  logic              req1_load,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              req1_err,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_load,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_ready,
    output logic              busy
);

    localparam int unsigned    CNT_W  = cnt_width(TIMEOUT);
    localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [1:0]        ready_q, ready_d;
    logic [1:0]        err_q, err_d;

    logic [1:0]        arb_gnt;
    logic              gnt_load;
    logic              keep;
    logic [CNT_W:0]    cnt_inc;
    logic              timed_out;
    logic [DATA_W-1:0] resp_data;

    rr_arbiter2 u_arb (
        .req         ({req1_load, req0_load}),
        .last_served (last_q),
        .fixed_pri   (FIXED_PRI),
        .gnt         (arb_gnt)
    );

    assign gnt_load  = gnt_q ? req1_load : req0_load;
    assign keep      = !drop_q && gnt_load;
    assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
    assign timed_out = (cnt_inc >= TO_LIM);
    assign resp_data = rom_ready ? rom_data : '1;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        drop_d   = drop_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        ready_d  = 2'b00;
        err_d    = 2'b00;
        rom_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    state_d = ST_ISSUE;
                    gnt_d   = arb_gnt[1];
                    last_d  = arb_gnt[1];
                    drop_d  = 1'b0;
                    addr_d  = arb_gnt[1] ? req1_addr : req0_addr;
                end
            end
            ST_ISSUE: begin
                state_d  = ST_WAIT;
                cnt_d    = '0;
                rom_load = 1'b1;
                if (!gnt_load) begin
                    drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (rom_ready || timed_out) begin
                    state_d = ST_RESP;
                    // An abandoned request still drains the ROM cycle silently.
                    if (keep) begin
                        ready_d[gnt_q] = 1'b1;
                        err_d[gnt_q]   = !rom_ready;
                        if (gnt_q) begin
                            data1_d = resp_data;
                        end else begin
                            data0_d = resp_data;
                        end
                    end
                end else if (!gnt_load) begin
                    drop_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            ready_q <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign rom_addr   = addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign req0_data  = data0_q;
    assign req1_data  = data1_q;
    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are listed below, clock and reset first.
REQ-002 Parameters SHALL be (name, default, meaning):
- ADDR_W, 24, ROM address width.
- DATA_W, 16, ROM data width.
- TIMEOUT, 255, maximum WAIT cycles.
- FIXED_PRI, 0; 1 means requester 0 always wins, 0 means round-robin.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- req0_load, in, 1, requester 0 (sound) read request, level.
- req0_addr, in, ADDR_W, requester 0 word address.
- req0_data, out, DATA_W, requester 0 read data.
- req0_ready, out, 1, requester 0 completion pulse.
- req0_err, out, 1, requester 0 timeout flag, valid with ready.
- req1_load, req1_addr, req1_data, req1_ready, req1_err: same as requester 0, for requester 1 (dma).
- rom_addr, out, ADDR_W, address to the ROM controller.
- rom_load, out, 1, ROM controller start pulse.
- rom_data, in, DATA_W, ROM controller data.
- rom_ready, in, 1, ROM controller done.
- busy, out, 1, high in every state except IDLE.

Function
REQ-004 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, with these transitions:
- IDLE to ISSUE when any reqN_load is high.
- ISSUE to WAIT always.
- WAIT to RESP on rom_ready or on timeout.
- RESP to IDLE always.
REQ-005 In IDLE, the grant SHALL be decided as follows:
- A single request is granted immediately.
- On a simultaneous request with FIXED_PRI=1, requester 0 wins.
- On a simultaneous request with FIXED_PRI=0, the requester not served last wins; the last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-006 The grant index and the granted address SHALL be registered on the IDLE-to-ISSUE edge; rom_addr SHALL hold the registered address from ISSUE through RESP.
REQ-007 rom_load SHALL be high for exactly one cycle, the ISSUE cycle, and low in all other states.
REQ-008 In WAIT, rom_ready SHALL be sampled only from the first WAIT cycle; rom_ready high during ISSUE SHALL be ignored.
REQ-009 On rom_ready in WAIT, rom_data SHALL be captured into the granted requester's reqN_data register.
REQ-010 The timeout count SHALL work as follows:
- A counter of ceil(log2(TIMEOUT+1)) bits clears in ISSUE and increments each WAIT cycle.
- When it reaches TIMEOUT with no rom_ready, the FSM goes to RESP.
- The granted reqN_data is then loaded with all ones and reqN_err is set.
REQ-011 In RESP, the granted reqN_ready SHALL be high for exactly one cycle, with reqN_err valid in that same cycle; the other requester's ready SHALL stay low.
REQ-012 reqN_data SHALL hold its value until that requester's next completion.
REQ-013 Minimum latency SHALL be 4 cycles from req_load high to req_ready, with rom_ready in the first WAIT cycle: cycle N IDLE, N+1 ISSUE, N+2 WAIT, N+3 RESP.
REQ-014 Requester protocol SHALL be as follows:
- A requester holds load and addr stable until it sees ready, then drops load on the next edge.
- A requester whose load is still high in the IDLE cycle after RESP is treated as a new request.
REQ-015 If the granted requester drops load during ISSUE or WAIT, the ROM cycle SHALL still complete; data is discarded and no reqN_ready pulse is issued.
REQ-016 A request from the non-granted requester during a transaction SHALL be held off, not lost, and arbitrated at the next IDLE.
REQ-017 A rom_ready pulse in IDLE or RESP SHALL be ignored.

Reset
REQ-018 When rst is high on a clock edge, regardless of state:
- The FSM goes to IDLE.
- rom_load, busy, both reqN_ready and both reqN_err go to 0.
- rom_addr and both reqN_data go to 0.
- The timeout counter goes to 0.
- The last-served pointer goes to 1.
REQ-019 A reset asserted mid-transaction SHALL abort it with no ready pulse; a late rom_ready after reset SHALL be ignored, per REQ-017.

Structure
REQ-020 The FSM state encoding and the default ADDR_W, DATA_W and TIMEOUT values SHALL live in the shared system package.
REQ-021 Arbitration SHALL be a single sub-module, rr_arbiter2, which takes two requests, the last-served pointer and FIXED_PRI, and returns a one-hot grant; the FSM and datapath stay in rom_arbiter.

Verification
REQ-022 Single request: req0_load=1 with addr 0x000100; rom_ready in the first WAIT cycle with data 0xBEEF. Required response: rom_load pulses once with rom_addr=0x000100; req0_ready pulses at cycle N+3 with req0_data=0xBEEF and req0_err=0.
REQ-023 Simultaneous requests: both loads high out of reset with FIXED_PRI=0. Required response: requester 0 is served first, then requester 1; ten back-to-back tie cycles give a 5/5 alternation.
REQ-024 Fixed priority: FIXED_PRI=1 with both loads held continuously. Required response: only requester 0 is served until its load drops, then requester 1.
REQ-025 Timeout: TIMEOUT=8 and rom_ready never asserted. Required response: req1_ready pulses 8 WAIT cycles after ISSUE with req1_data=0xFFFF and req1_err=1; the next transaction proceeds normally.
REQ-026 Reset mid-WAIT: rst is pulsed during WAIT, then rom_ready arrives. Required response: no ready pulse, all outputs return to 0, busy=0.
REQ-027 Dropped request: req0_load drops during WAIT. Required response: the ROM cycle completes, no req0_ready pulse, req0_data is unchanged, and a pending req1 is granted at the next IDLE.
